// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_gen
// Brief    : Runtime-programmable multi-channel clock-enable generator.
//            Each channel emits a one-cycle tick every div+1 cycles, an
//            optional 50% square wave, and a locked flag once the period
//            has been stable for LOCK_PERIODS ticks. New settings are
//            applied only at a period boundary, or immediately while the
//            channel is disabled.
// Options  : define CLK_EN_GEN_SQUARE_EN to build the square-wave flops;
//            otherwise sq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module clk_en_gen #(
  parameter int NUM_CH       = 2,
  parameter int DIV_WIDTH    = 16,
  parameter int DEFAULT_DIV  = 1,
  parameter bit RESET_EN     = 1'b1,
  parameter int LOCK_PERIODS = 4,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_chan,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_en,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    sq,
  output logic [NUM_CH-1:0]    locked
);

  localparam int                   c_LC_W     = $clog2(LOCK_PERIODS + 1);
  localparam logic [DIV_WIDTH-1:0] c_DEF_DIV  = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [c_LC_W-1:0]    c_LOCK_MAX = c_LC_W'(LOCK_PERIODS);

  // Per-channel pending flags, gathered so the handshake can index them.
  logic [NUM_CH-1:0] w_pend;
  logic              w_chan_ok;

  // Ready reflects only the addressed channel's pending flag; writes to
  // non-existent channels are always accepted and dropped.
  always_comb begin
    w_chan_ok = ({1'b0, cfg_chan} < (CH_W + 1)'(NUM_CH));
    cfg_ready = 1'b1;
    if (w_chan_ok) begin
      cfg_ready = ~w_pend[cfg_chan];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_pdiv;
    logic                 r_en;
    logic                 r_pen;
    logic                 r_pend;
    logic [c_LC_W-1:0]    r_lc;
    logic                 r_tick;
    logic                 r_locked;
    logic [c_LC_W-1:0]    w_lc_inc;
    logic [c_LC_W-1:0]    w_lc_next;
    logic                 w_acc;
    logic                 w_wrap;
    logic                 w_apply;

    assign w_acc     = cfg_valid && cfg_ready && w_chan_ok && (cfg_chan == CH_W'(i));
    assign w_wrap    = r_en && (r_cnt == r_div);
    // Pending settings land at a period boundary, or at once if idle.
    assign w_apply   = r_pend && (w_wrap || !r_en);
    assign w_lc_inc  = (r_lc == c_LOCK_MAX) ? r_lc : r_lc + c_LC_W'(1);
    assign w_lc_next = w_wrap ? w_lc_inc : r_lc;

    assign w_pend[i] = r_pend;
    assign tick[i]   = r_tick;
    assign locked[i] = r_locked;

    // Divider, pending-write capture, apply and lock tracking.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_div    <= c_DEF_DIV;
        r_en     <= RESET_EN;
        r_cnt    <= '0;
        r_pdiv   <= '0;
        r_pen    <= 1'b0;
        r_pend   <= 1'b0;
        r_lc     <= '0;
        r_tick   <= 1'b0;
        r_locked <= 1'b0;
      end else begin
        // The outgoing period always completes, even on an apply edge.
        r_tick <= w_wrap;
        // Accept needs pend low and apply needs pend high: never both.
        if (w_acc) begin
          r_pend <= 1'b1;
          r_pdiv <= cfg_div;
          r_pen  <= cfg_en;
        end
        if (w_apply) begin
          r_div    <= r_pdiv;
          r_en     <= r_pen;
          r_cnt    <= '0;
          r_pend   <= 1'b0;
          r_lc     <= '0;
          r_locked <= 1'b0;
        end else if (r_en) begin
          r_cnt    <= w_wrap ? '0 : r_cnt + DIV_WIDTH'(1);
          r_lc     <= w_lc_next;
          r_locked <= (w_lc_next == c_LOCK_MAX);
        end else begin
          r_cnt    <= '0;
          r_lc     <= '0;
          r_locked <= 1'b0;
        end
      end
    end

`ifdef CLK_EN_GEN_SQUARE_EN
    logic r_sq;

    // Toggle on every wrap for a 2(D+1) period; parked low while disabled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sq <= 1'b0;
      end else if (w_wrap) begin
        r_sq <= ~r_sq;
      end else if (!r_en) begin
        r_sq <= 1'b0;
      end
    end

    assign sq[i] = r_sq;
`else
    assign sq[i] = 1'b0;
`endif
  end

endmodule
`default_nettype wire
